// File: rtl/aor_unlock_pkg.sv
// Shared types and helpers for the AOR key-unlock controller: FSM states,
// self-test LFSR taps and the key checksum fold.
package aor_unlock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    TEST,
    UNLOCKED,
    FAIL
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Widest key the checksum helper folds; narrower keys are zero-extended.
  localparam int KEY_W_MAX = 256;

  function automatic logic [7:0] key_checksum(input logic [KEY_W_MAX-1:0] key);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < KEY_W_MAX / 8; i++) begin
      acc ^= key[i*8 +: 8];
    end
    return acc;
  endfunction

  // Right-shifting Galois step; the tap mask is applied when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/aor_lfsr32.sv
// 32-bit Galois LFSR with a reset seed and an advance enable; also used by
// the random-key simulation benches.
module aor_lfsr32
  import aor_unlock_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/aor_key_unlock_ctrl.sv
// AOR unlock controller: serial key load, checksum check, key commit and
// LFSR self-test of the locked adder. Define AOR_PARTIAL_KEY_EN for partial_mask_i.
module aor_key_unlock_ctrl
  import aor_unlock_pkg::*;
#(
  parameter int          KEY_W     = 64,
  parameter int          DATA_W    = 32,
  parameter int          NUM_VEC   = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           key_bit_i,
  input  logic                           key_bit_valid_i,
  output logic                           key_bit_ready_o,
  output logic [KEY_W-1:0]               keyinput_o,
  output logic [DATA_W-1:0]              add1_o,
  output logic [DATA_W-1:0]              add2_o,
  input  logic [DATA_W:0]                result_i,
`ifdef AOR_PARTIAL_KEY_EN
  input  logic [KEY_W-1:0]               partial_mask_i,
`endif
  output logic                           busy_o,
  output logic                           unlocked_o,
  output logic                           fail_o,
  output logic [$clog2(NUM_VEC+1)-1:0]   err_cnt_o
);

  localparam int LOAD_BITS = KEY_W + 8;
  localparam int CNT_W     = $clog2(LOAD_BITS + 1);
  localparam int ERR_W     = $clog2(NUM_VEC + 1);

  state_e                r_state, w_state_nxt;
  logic [LOAD_BITS-1:0]  r_shadow;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [ERR_W-1:0]      r_vec_cnt;
  logic [ERR_W-1:0]      r_err_cnt;
  logic [KEY_W-1:0]      r_keyinput;
  logic [DATA_W-1:0]     r_add1, r_add2;
  logic                  r_unlocked, r_fail;

  logic [31:0]           w_lfsr;
  logic                  w_lfsr_en;
  logic                  w_bit_xfer, w_load_done;
  logic [KEY_W-1:0]      w_key, w_commit_key;
  logic [7:0]            w_cks;
  logic                  w_cks_ok;
  logic [DATA_W:0]       w_sum;
  logic                  w_mismatch, w_last_vec;
  logic [ERR_W-1:0]      w_err_nxt;
  logic [DATA_W-1:0]     w_op1, w_op2;

  // Shadow holds key bit 0 at index 0 and the checksum on top once full.
  assign w_key       = r_shadow[KEY_W-1:0];
  assign w_cks       = r_shadow[LOAD_BITS-1 -: 8];
  assign w_cks_ok    = key_checksum(KEY_W_MAX'(w_key)) == w_cks;
  assign w_bit_xfer  = (r_state == LOAD) && key_bit_valid_i;
  assign w_load_done = w_bit_xfer && (r_bit_cnt == CNT_W'(LOAD_BITS - 1));

  assign w_op1 = DATA_W'(w_lfsr);
  assign w_op2 = DATA_W'({w_lfsr[15:0], w_lfsr[31:16]});

  assign w_sum      = {1'b0, r_add1} + {1'b0, r_add2};
  assign w_mismatch = result_i != w_sum;
  assign w_last_vec = r_vec_cnt == ERR_W'(NUM_VEC - 1);
  assign w_err_nxt  = (w_mismatch && (r_err_cnt < ERR_W'(NUM_VEC))) ? r_err_cnt + 1'b1
                                                                    : r_err_cnt;

  assign w_lfsr_en = ((r_state == CHECK) && w_cks_ok) ||
                     ((r_state == TEST) && !w_last_vec);

  aor_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_lfsr_en),
    .o_state (w_lfsr)
  );

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_commit_key = w_key;
`ifdef AOR_PARTIAL_KEY_EN
    for (int i = 0; i < KEY_W; i++) begin
      if (partial_mask_i[i]) w_commit_key[i] = w_lfsr[i % 32];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    key_bit_ready_o = 1'b0;
    busy_o          = 1'b0;
    case (r_state)
      IDLE, UNLOCKED, FAIL: begin
        if (start_i) w_state_nxt = LOAD;
      end
      LOAD: begin
        key_bit_ready_o = 1'b1;
        busy_o          = 1'b1;
        if (w_load_done) w_state_nxt = CHECK;
      end
      CHECK: begin
        busy_o      = 1'b1;
        w_state_nxt = w_cks_ok ? TEST : FAIL;
      end
      TEST: begin
        busy_o = 1'b1;
        if (w_last_vec) w_state_nxt = (w_err_nxt == '0) ? UNLOCKED : FAIL;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the shadow key register is reset too, so no loaded secret survives
  // a reset even though it is fully overwritten by every complete load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_bit_cnt  <= '0;
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_keyinput <= '0;
      r_add1     <= '0;
      r_add2     <= '0;
      r_unlocked <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, UNLOCKED, FAIL: begin
          if (start_i) begin
            r_unlocked <= 1'b0;
            r_fail     <= 1'b0;
            r_err_cnt  <= '0;
            r_keyinput <= '0;
            r_bit_cnt  <= '0;
          end
        end
        LOAD: begin
          if (w_bit_xfer) begin
            r_shadow  <= {key_bit_i, r_shadow[LOAD_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (w_cks_ok) begin
            r_keyinput <= w_commit_key;
            r_add1     <= w_op1;
            r_add2     <= w_op2;
            r_vec_cnt  <= '0;
          end else begin
            r_fail <= 1'b1;
          end
        end
        TEST: begin
          r_err_cnt <= w_err_nxt;
          if (w_last_vec) begin
            r_add1 <= '0;
            r_add2 <= '0;
            if (w_err_nxt == '0) begin
              r_unlocked <= 1'b1;
            end else begin
              r_fail     <= 1'b1;
              r_keyinput <= '0;
            end
          end else begin
            r_add1    <= w_op1;
            r_add2    <= w_op2;
            r_vec_cnt <= r_vec_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign keyinput_o = r_keyinput;
  assign add1_o     = r_add1;
  assign add2_o     = r_add2;
  assign unlocked_o = r_unlocked;
  assign fail_o     = r_fail;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_aor_key_unlock_ctrl.sv
// Randomized self-checking bench for aor_key_unlock_ctrl against a
// transaction-level model of load, checksum, commit and self-test.
module tb_aor_key_unlock_ctrl;

  localparam int          KEY_W   = 64;
  localparam int          DATA_W  = 32;
  localparam int          NUM_VEC = 16;
  localparam logic [31:0] SEED    = 32'hACE1_2345;
  localparam logic [63:0] GOLDEN  = 64'h0CA6_2A6B_A0D1_A712;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              key_bit_i = 1'b0;
  logic              key_bit_valid_i = 1'b0;
  logic              key_bit_ready_o;
  logic [KEY_W-1:0]  keyinput_o;
  logic [DATA_W-1:0] add1_o, add2_o;
  logic [DATA_W:0]   result_i;
  logic              busy_o, unlocked_o, fail_o;
  logic [4:0]        err_cnt_o;
`ifdef AOR_PARTIAL_KEY_EN
  logic [KEY_W-1:0]  partial_mask_i = '0;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  aor_key_unlock_ctrl #(
    .KEY_W     (KEY_W),
    .DATA_W    (DATA_W),
    .NUM_VEC   (NUM_VEC),
    .LFSR_SEED (SEED)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .key_bit_i       (key_bit_i),
    .key_bit_valid_i (key_bit_valid_i),
    .key_bit_ready_o (key_bit_ready_o),
    .keyinput_o      (keyinput_o),
    .add1_o          (add1_o),
    .add2_o          (add2_o),
    .result_i        (result_i),
`ifdef AOR_PARTIAL_KEY_EN
    .partial_mask_i  (partial_mask_i),
`endif
    .busy_o          (busy_o),
    .unlocked_o      (unlocked_o),
    .fail_o          (fail_o),
    .err_cnt_o       (err_cnt_o)
  );

  // Locked adder: exact with the golden key, otherwise operand-dependent
  // corruption driven by the key difference.
  function automatic logic [32:0] adder_ref(input logic [63:0] key,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] d;
    logic [31:0] d32;
    d   = key ^ GOLDEN;
    d32 = d[31:0] ^ d[63:32];
    return ({1'b0, a} + {1'b0, b}) ^ {1'b0, d32 & (a | 32'h1)};
  endfunction

  always_comb result_i = adder_ref(keyinput_o, add1_o, add2_o);

  function automatic logic [7:0] cks_ref(input logic [63:0] key);
    logic [7:0]  c;
    logic [63:0] k;
    c = 8'h00;
    k = key;
    for (int i = 0; i < 8; i++) begin
      c ^= k[7:0];
      k = k >> 8;
    end
    return c;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_key"},  keyinput_o, 0);
    check({tag, "_add1"}, add1_o, 0);
    check({tag, "_add2"}, add2_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_rdy"},  key_bit_ready_o, 0);
    check({tag, "_unl"},  unlocked_o, 0);
    check({tag, "_fail"}, fail_o, 0);
    check({tag, "_err"},  err_cnt_o, 0);
  endtask

  // One full transaction: start, serial load, then observe check and test.
  task automatic run_load(input logic [63:0] key, input logic [7:0] cks,
                          input logic [63:0] mask, input bit gaps,
                          input bit strays, input int abort_at);
    logic [71:0] bits;
    logic [31:0] lf;
    logic [31:0] q_a1[$];
    logic [31:0] q_a2[$];
    logic [63:0] commit, exp_key;
    bit          ok, exp_unl;
    int          exp_err, n_test, budget;

    // Expected outcome from the model.
    lf      = m_lfsr;
    ok      = cks_ref(key) == cks;
    commit  = 64'h0;
    exp_err = 0;
    if (ok) begin
      commit = key;
      for (int b = 0; b < 64; b++) if (mask[b]) commit[b] = lf[b % 32];
      for (int v = 0; v < NUM_VEC; v++) begin
        q_a1.push_back(lf);
        q_a2.push_back({lf[15:0], lf[31:16]});
        if (adder_ref(commit, lf, {lf[15:0], lf[31:16]}) != ({1'b0, lf} + {1'b0, lf[15:0], lf[31:16]}))
          exp_err++;
        lf = lfsr_next(lf);
      end
    end
    exp_unl = ok && (exp_err == 0);
    exp_key = exp_unl ? commit : 64'h0;

    bits = {cks, key};
`ifdef AOR_PARTIAL_KEY_EN
    partial_mask_i = mask;
`endif
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ld_ready", key_bit_ready_o, 1);
    check("ld_busy",  busy_o, 1);
    check("ld_unl",   unlocked_o, 0);
    check("ld_fail",  fail_o, 0);
    check("ld_err",   err_cnt_o, 0);
    check("ld_key",   keyinput_o, 0);

    for (int i = 0; i < 72; i++) begin
      if (i == abort_at) begin
        key_bit_valid_i = 1'b0;
        rst_n   = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        start_i = 1'b0;
        check_idle_zero("rst_mid");
        m_lfsr = SEED;
        return;
      end
      if (gaps) begin
        key_bit_valid_i = 1'b0;
        key_bit_i       = 1'($urandom);
        if (strays) start_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      key_bit_valid_i = 1'b1;
      key_bit_i       = bits[i];
      @(posedge clk); #1;
    end
    key_bit_valid_i = 1'b0;
    check("chk_busy",  busy_o, 1);
    check("chk_ready", key_bit_ready_o, 0);

    n_test = 0;
    budget = 0;
    while (busy_o && budget < 100) begin
      @(posedge clk); #1;
      budget++;
      if (busy_o) begin
        if (n_test == 0) check("commit_key", keyinput_o, commit);
        if (n_test < q_a1.size()) begin
          check("test_add1", add1_o, q_a1[n_test]);
          check("test_add2", add2_o, q_a2[n_test]);
        end
        n_test++;
      end
    end
    check("done_timeout", budget < 100, 1);
    check("test_cycles",  n_test, ok ? NUM_VEC : 0);
    check("end_unl",      unlocked_o, exp_unl);
    check("end_fail",     fail_o, !exp_unl);
    check("end_err",      err_cnt_o, exp_err);
    check("end_key",      keyinput_o, exp_key);
    check("end_add1",     add1_o, 0);
    check("end_add2",     add2_o, 0);
    m_lfsr = lf;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    logic [7:0]  c;
    int          sel, ab;
    m_lfsr = SEED;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_zero("reset");

    run_load(GOLDEN, 8'h2F, 64'h0, 1'b0, 1'b0, -1);
    check("golden_unl", unlocked_o, 1);
    check("golden_key", keyinput_o, GOLDEN);
    run_load(GOLDEN, 8'h2E, 64'h0, 1'b0, 1'b0, -1);
    check("badcks_fail", fail_o, 1);
    run_load(GOLDEN ^ 64'h1, 8'h2E, 64'h0, 1'b0, 1'b0, -1);
    check("flip_err_nz", err_cnt_o != 0, 1);
    run_load(GOLDEN, 8'h2F, 64'h0, 1'b1, 1'b1, -1);
    check("gaps_unl", unlocked_o, 1);
    run_load(GOLDEN, 8'h2F, 64'h0, 1'b0, 1'b0, 40);
    run_load(GOLDEN, 8'h2F, 64'h0, 1'b0, 1'b0, -1);
    check("post_rst_unl", unlocked_o, 1);
`ifdef AOR_PARTIAL_KEY_EN
    run_load(GOLDEN, 8'h2F, 64'h0, 1'b0, 1'b0, -1);
    check("mask0_unl", unlocked_o, 1);
    run_load(GOLDEN, 8'h2F, 64'hFFFF_0000_0000_0000, 1'b0, 1'b0, -1);
`endif

    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 3);
      k   = {$urandom, $urandom};
      case (sel)
        0:       begin k = GOLDEN; c = cks_ref(k); end
        1:       c = cks_ref(k);
        2:       c = cks_ref(k) ^ 8'($urandom_range(1, 255));
        default: begin k = GOLDEN ^ (64'h1 << $urandom_range(0, 63)); c = cks_ref(k); end
      endcase
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 71) : -1;
      run_load(k, c, 64'h0, 1'($urandom), 1'($urandom), ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
